// File: rtl/frost32_mul_div_unit_pkg.sv
// Shared types for the Frost32 iterative multiply/divide unit.
// Also carries the mul_div_defines macro MSB_POS__MUL_DIV_OPER.
`ifndef MSB_POS__MUL_DIV_OPER
`define MSB_POS__MUL_DIV_OPER 2
`endif

package frost32_mul_div_unit_pkg;

  typedef enum logic [`MSB_POS__MUL_DIV_OPER:0] {
    MdMul   = 3'd0,
    MdMulhu = 3'd1,
    MdMulhs = 3'd2,
    MdUdiv  = 3'd3,
    MdSdiv  = 3'd4,
    MdUmod  = 3'd5,
    MdSmod  = 3'd6,
    MdRsvd  = 3'd7
  } mul_div_oper_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } mul_div_state_e;

  function automatic logic oper_is_mul(input mul_div_oper_e op);
    return (op == MdMul) || (op == MdMulhu) || (op == MdMulhs);
  endfunction

  function automatic logic oper_is_div(input mul_div_oper_e op);
    return (op == MdUdiv) || (op == MdSdiv) || (op == MdUmod) || (op == MdSmod);
  endfunction

  function automatic logic oper_is_signed(input mul_div_oper_e op);
    return (op == MdMulhs) || (op == MdSdiv) || (op == MdSmod);
  endfunction

endpackage

// File: rtl/frost32_mul_div_unit_if.sv
// Start/busy/done request bus between the execute stage and the mul/div unit.
interface frost32_mul_div_unit_if
  import frost32_mul_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  mul_div_oper_e         oper;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  div_by_zero;

  modport master (
    output start, oper, a, b, flush,
    input  busy, done, result, div_by_zero
  );

  modport slave (
    input  start, oper, a, b, flush,
    output busy, done, result, div_by_zero
  );
endinterface

// File: rtl/frost32_mul_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide engine with start/busy/done handshake.
// FROST32_MUL_DIV_EARLY_OUT_EN: trivial operands skip StRun (latency 2).
//
// state    | meaning
// StIdle   | waiting for start; result/div_by_zero hold last value
// StRun    | one shift-add / shift-subtract step per cycle
// StFinish | sign correction, word select, result register and done pulse
module frost32_mul_div_unit
  import frost32_mul_div_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input logic                   clk,
  input logic                   rst_n,
  frost32_mul_div_unit_if.slave bus
);

  localparam int W = DATA_WIDTH;

  mul_div_state_e   state;
  mul_div_oper_e    oper_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic             neg_q;
  logic             dz_q;
  logic [W-1:0]     opnd_q;
  // mul: {partial product high, multiplier/low product}; div: {remainder, quotient}
  logic [2*W-1:0]   acc;

  logic             op_signed, sa, sb, neg_in, is_mul_in, is_div_in;
  logic [W-1:0]     abs_a, abs_b;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic [W:0]       div_shift;
  logic             div_borrow;
  logic [W-1:0]     div_diff;
  logic [2*W-1:0]   div_next;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quo_fix, rem_fix;
  logic [W-1:0]     result_next;

  function automatic logic [W-1:0] sign_fix(input logic [W-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  always_comb begin
    is_mul_in = oper_is_mul(bus.oper);
    is_div_in = oper_is_div(bus.oper);
    op_signed = oper_is_signed(bus.oper);
    sa        = op_signed & bus.a[W-1];
    sb        = op_signed & bus.b[W-1];
    abs_a     = sa ? -bus.a : bus.a;
    abs_b     = sb ? -bus.b : bus.b;
    case (bus.oper)
      MdMulhs, MdSdiv: neg_in = sa ^ sb;
      MdSmod:          neg_in = sa;
      default:         neg_in = 1'b0;
    endcase
  end

`ifdef FROST32_MUL_DIV_EARLY_OUT_EN
  logic           early_in;
  logic [2*W-1:0] early_acc;

  always_comb begin
    early_in = (bus.b == '0) ||
               ((is_mul_in || is_div_in) && (bus.a == '0));
    // b == 0 divide lands directly on the final quotient/remainder pair
    early_acc = (is_div_in && (bus.b == '0)) ? {abs_a, {W{1'b1}}} : '0;
  end
`endif

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc[W-1:1]};

    div_shift  = {acc[2*W-1:W], acc[W-1]};
    div_borrow = div_shift < {1'b0, opnd_q};
    div_diff   = div_shift[W-1:0] - opnd_q;
    div_next   = div_borrow ? {div_shift[W-1:0], acc[W-2:0], 1'b0}
                            : {div_diff,          acc[W-2:0], 1'b1};
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = sign_fix(acc[W-1:0], neg_q);
    rem_fix  = sign_fix(acc[2*W-1:W], neg_q);
    case (oper_q)
      MdMul:           result_next = prod_fix[W-1:0];
      MdMulhu, MdMulhs: result_next = prod_fix[2*W-1:W];
      MdUdiv, MdSdiv:  result_next = dz_q ? {W{1'b1}} : quo_fix;
      MdUmod, MdSmod:  result_next = rem_fix;
      default:         result_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= StIdle;
      oper_q          <= MdMul;
      cnt             <= '0;
      neg_q           <= 1'b0;
      dz_q            <= 1'b0;
      opnd_q          <= '0;
      acc             <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.result      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.flush) begin
        state    <= StIdle;
        bus.busy <= 1'b0;
      end else begin
        case (state)
          StIdle: begin
            if (bus.start) begin
              oper_q   <= bus.oper;
              neg_q    <= neg_in;
              dz_q     <= is_div_in && (bus.b == '0);
              opnd_q   <= is_mul_in ? abs_a : abs_b;
              cnt      <= CNT_WIDTH'(W - 1);
              bus.busy <= 1'b1;
`ifdef FROST32_MUL_DIV_EARLY_OUT_EN
              if (early_in) begin
                state <= StFinish;
                acc   <= early_acc;
              end else
`endif
              begin
                state <= StRun;
                acc   <= {{W{1'b0}}, (is_mul_in ? abs_b : abs_a)};
              end
            end
          end
          StRun: begin
            acc <= oper_is_mul(oper_q) ? mul_next : div_next;
            cnt <= cnt - CNT_WIDTH'(1);
            if (cnt == '0) state <= StFinish;
          end
          StFinish: begin
            bus.result      <= result_next;
            bus.div_by_zero <= dz_q;
            bus.done        <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= StIdle;
          end
          default: begin
            state    <= StIdle;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/frost32_mul_div_unit.md
Name: frost32_mul_div_unit

Overview:
Iterative, parametrised multiply/divide unit for the Frost32 execute stage. It replaces the non-synthesizeable "*" in write-back with a start/busy/done multi-cycle engine. The decode stage's stall counter is driven from busy/done instead of a fixed count of 3. It adds division, remainder, high-word multiply and pipeline flush, none of which the current core has.

Parameters:
DATA_WIDTH, 32, operand/result width; even, >= 8
CNT_WIDTH, $clog2(DATA_WIDTH), width of iteration counter (derived; do not override)

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in StIdle
oper  in  3  PkgMulDiv::MulDivOper, sampled with start
a  in  DATA_WIDTH  operand A (multiplicand / dividend), sampled with start
b  in  DATA_WIDTH  operand B (multiplier / divisor), sampled with start
flush  in  1  cancel current operation (branch/pipeline flush)
busy  out  1  high while an accepted operation is in progress
done  out  1  one-cycle pulse, result valid
result  out  DATA_WIDTH  result; held from done until next done
div_by_zero  out  1  set with done when a div/mod had b == 0; held like result

Behaviour:
- Reset (async, rst_n low): state StIdle; busy=0, done=0, result=0, div_by_zero=0, counter=0, internal accumulators=0.
- Opers: MdMul=0 (low W of a*b), MdMulhu=1 (high W, unsigned), MdMulhs=2 (high W, signed x signed), MdUdiv=3, MdSdiv=4, MdUmod=5, MdSmod=6, 7 reserved.
- FSM: StIdle -> StRun -> StFinish -> StIdle.
- StIdle: if start && !flush, latch oper/a/b and go to StRun; busy=1 from next cycle; counter=DATA_WIDTH-1.
- Signed opers latch absolute values plus result-sign bits: quotient sign = sa^sb; remainder sign = sa; product sign = sa^sb.
- StRun: one bit per cycle.
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract into a W remainder and W quotient.
  - Counter decrements each cycle; at counter==0 go to StFinish.
- StFinish: apply sign correction (two's-complement negate), select the word, register result, pulse done=1 for this cycle, busy=0 on the following cycle, return to StIdle.
- Latency: start sampled at edge 0; done high in the cycle after edge DATA_WIDTH+1. Throughput: one op per DATA_WIDTH+2 cycles (start is accepted again in the cycle done is high? No; start is accepted only in StIdle, the cycle after done).
- start while busy: ignored, no queueing.
- flush: in any state, next edge goes to StIdle, busy=0, done not asserted, result/div_by_zero unchanged. flush and start in the same cycle: flush wins, nothing accepted.
- Divide by zero (b==0): quotient = all ones, remainder = a (unsigned or signed, unmodified); div_by_zero=1. Normal latency unless the optional feature is enabled.
- Signed overflow (Sdiv/Smod with a = MIN and b = -1): quotient = MIN, remainder = 0, div_by_zero=0.
- Reserved oper 7: runs normal latency, result = 0, div_by_zero = 0.
- done is never high in two consecutive cycles.
- rst_n asserted mid-operation: immediate return to reset values; no done.

Optional Feature:
FROST32_MUL_DIV_EARLY_OUT_EN
- Defined: if any of the following hold at start, skip StRun and go StIdle -> StFinish, so done is high the cycle after edge 1 (latency 2):
  - b == 0 on any oper;
  - a == 0 on a div/mod;
  - a == 0 or b == 0 on a multiply.
  Results are identical to the full-latency path.
- Undefined: every oper takes DATA_WIDTH+2 cycles regardless of operands.

Decomposition:
- Package PkgMulDiv holds:
  - enum MulDivOper (3 bits, values above);
  - enum MulDivState (StIdle, StRun, StFinish);
  - `define MSB_POS__MUL_DIV_OPER 2 in a mul_div_defines header.
- PkgInstrDecoder mapping from Mul_ThreeRegs/Muli_TwoRegsOneImm to MdMul stays in the CPU, not here.
- Single module, no sub-module: the sign fix is a small function inside the module.

Test Plan:
- MdMul, a=7, b=6 -> done exactly 34 cycles after start edge (W=32), result=42, busy high 33 cycles.
- MdMulhs, a=32'hFFFF_FFFE (-2), b=32'h0000_0003 -> result=32'hFFFF_FFFF; MdMulhu, same operands -> result=32'h0000_0002.
- MdSdiv, a=-7, b=2 -> result=-3 (32'hFFFF_FFFD); MdSmod, same operands -> result=-1; MdSdiv, a=32'h8000_0000, b=-1 -> result=32'h8000_0000, div_by_zero=0.
- MdUdiv, a=100, b=0 -> result=32'hFFFF_FFFF, div_by_zero=1; MdUmod, same operands -> result=100. With FROST32_MUL_DIV_EARLY_OUT_EN defined, done arrives 2 cycles after start.
- Flush: start MdMul; flush at cycle 10 -> busy=0 next cycle, no done, result keeps its previous value. start during busy is ignored: the result equals the first op's result.
- Reset: drop rst_n mid-StRun -> busy/done/result/div_by_zero=0 immediately (async); after release, a new MdMul 3*5 gives 15 at normal latency.
